// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Package : fc_pkg
// Brief   : Shared load-FSM states and field sizing for the FC parameter store
// Rev     : 1.0
// ============================================================================
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W     = 3'd1,
        S_MUL   = 3'd2,
        S_BIAS  = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } fc_ld_state_t;

    localparam int FC_MUL_W   = 16;
    localparam int FC_BIAS_W  = 32;
    localparam int MUL_BYTES  = FC_MUL_W / 8;
    localparam int BIAS_BYTES = FC_BIAS_W / 8;

    function automatic int fc_field_bytes(input int width);
        return width / 8;
    endfunction

    // Bytes per output-channel record: mul, bias, then one shift byte.
    function automatic int fc_record_bytes(input int mul_w, input int bias_w);
        return fc_field_bytes(mul_w) + fc_field_bytes(bias_w) + 1;
    endfunction

endpackage : fc_pkg
`default_nettype wire

// File: rtl/fc_param_store_if.sv
`default_nettype none
// ============================================================================
// Interface : fc_param_store_if
// Brief     : Byte-stream valid/ready channel from the DMA loader
// Rev       : 1.0
// ============================================================================
interface fc_param_store_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface : fc_param_store_if
`default_nettype wire

// File: rtl/fc_param_store_assembler.sv
`default_nettype none
// ============================================================================
// Module : fc_byte_assembler
// Brief  : Collects a little-endian multi-byte field, pulses field_done on its last byte
// Rev    : 1.0
// ============================================================================
module fc_byte_assembler #(
    parameter  int MAX_BYTES = 4,
    localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   byte_valid,
    input  wire logic [7:0]             byte_data,
    input  wire logic [CNT_W-1:0]       last_idx,
    output logic      [MAX_BYTES*8-1:0] field_value,
    output logic                        field_done
);

    logic [MAX_BYTES*8-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // field_value already includes the byte arriving this cycle so the
    // owner can commit the whole field on the same edge.
    always_comb begin
        field_value = acc_q;
        if (byte_valid) begin
            field_value[{cnt_q, 3'b000} +: 8] = byte_data;
        end
        field_done = byte_valid && (cnt_q == last_idx);
        acc_d      = field_value;
        cnt_d      = cnt_q;
        if (byte_valid) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (field_done) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule : fc_byte_assembler
`default_nettype wire

// File: rtl/fc_param_store.sv
`default_nettype none
// ============================================================================
// Module : fc_param_store
// Brief  : Loads FC weights and requant records from a byte stream; serves them combinationally
// Rev    : 1.0
// ============================================================================
module fc_param_store
    import fc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MUL_W      = 8 * MUL_BYTES,
    parameter int BIAS_W     = 8 * BIAS_BYTES,
    parameter int SHIFT_W    = 6,
    parameter int DIM_W      = 16,
    parameter int MAX_IN_CH  = 1024,
    parameter int MAX_OUT_CH = 1024
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      load_start,
    input  wire logic        [DIM_W-1:0]   cfg_in_c,
    input  wire logic        [DIM_W-1:0]   cfg_out_c,
    fc_param_store_if.slave                s_if,
    output logic                           load_busy,
    output logic                           load_done,
    output logic                           load_err,
    output logic                           loaded,
    input  wire logic        [DIM_W-1:0]   fc_in_idx,
    input  wire logic        [DIM_W-1:0]   fc_out_idx,
    output logic signed      [DATA_W-1:0]  fc_weight,
    output logic signed      [MUL_W-1:0]   fc_mul,
    output logic signed      [BIAS_W-1:0]  fc_bias,
    output logic             [SHIFT_W-1:0] fc_shift
);

    localparam int AW           = $clog2(MAX_IN_CH * MAX_OUT_CH);
    localparam int OW           = (MAX_OUT_CH > 1) ? $clog2(MAX_OUT_CH) : 1;
    localparam int L_MUL_BYTES  = fc_field_bytes(MUL_W);
    localparam int L_BIAS_BYTES = fc_field_bytes(BIAS_W);
    localparam int ASM_BYTES    = (L_MUL_BYTES > L_BIAS_BYTES) ? L_MUL_BYTES : L_BIAS_BYTES;
    localparam int ASM_CW       = (ASM_BYTES > 1) ? $clog2(ASM_BYTES) : 1;
    localparam logic [DIM_W-1:0] MAX_IN_V  = DIM_W'(MAX_IN_CH);
    localparam logic [DIM_W-1:0] MAX_OUT_V = DIM_W'(MAX_OUT_CH);

    logic [DATA_W-1:0]  wmem     [MAX_IN_CH*MAX_OUT_CH];
    logic [MUL_W-1:0]   mul_mem  [MAX_OUT_CH];
    logic [BIAS_W-1:0]  bias_mem [MAX_OUT_CH];
    logic [SHIFT_W-1:0] shift_mem[MAX_OUT_CH];

    fc_ld_state_t     state_q, state_d;
    logic [DIM_W-1:0] in_c_q, in_c_d;
    logic [DIM_W-1:0] out_c_q, out_c_d;
    logic [DIM_W-1:0] o_q, o_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [AW-1:0]    wlast_q, wlast_d;
    logic             s_ready_q, s_ready_d;
    logic             load_busy_q, load_busy_d;
    logic             load_done_q, load_done_d;
    logic             load_err_q, load_err_d;
    logic             loaded_q, loaded_d;

    logic                   hs;
    logic                   cfg_bad;
    logic [2*DIM_W-1:0]     cfg_prod;
    logic                   asm_valid;
    logic [ASM_CW-1:0]      asm_last;
    logic [ASM_BYTES*8-1:0] asm_value;
    logic                   asm_done;
    logic                   w_we, mul_we, bias_we, shift_we;

    assign hs          = s_if.s_valid & s_ready_q;
    assign s_if.s_ready = s_ready_q;
    assign load_busy   = load_busy_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign loaded      = loaded_q;

    assign cfg_prod = {{DIM_W{1'b0}}, cfg_in_c} * {{DIM_W{1'b0}}, cfg_out_c};
    assign cfg_bad  = (cfg_in_c == '0) || (cfg_out_c == '0) ||
                      (cfg_in_c > MAX_IN_V) || (cfg_out_c > MAX_OUT_V);

    // Mul and bias share one assembler; only the field length differs.
    assign asm_valid = hs && ((state_q == S_MUL) || (state_q == S_BIAS));
    assign asm_last  = (state_q == S_MUL) ? ASM_CW'(L_MUL_BYTES - 1)
                                          : ASM_CW'(L_BIAS_BYTES - 1);

    fc_byte_assembler #(
        .MAX_BYTES (ASM_BYTES)
    ) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_valid  (asm_valid),
        .byte_data   (s_if.s_data),
        .last_idx    (asm_last),
        .field_value (asm_value),
        .field_done  (asm_done)
    );

    assign w_we     = hs && (state_q == S_W);
    assign mul_we   = asm_done && (state_q == S_MUL);
    assign bias_we  = asm_done && (state_q == S_BIAS);
    assign shift_we = hs && (state_q == S_SHIFT);

    always_comb begin
        state_d     = state_q;
        in_c_d      = in_c_q;
        out_c_d     = out_c_q;
        o_d         = o_q;
        waddr_d     = waddr_q;
        wlast_d     = wlast_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        loaded_d    = loaded_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (cfg_bad) begin
                        load_err_d = 1'b1;
                    end else begin
                        in_c_d   = cfg_in_c;
                        out_c_d  = cfg_out_c;
                        wlast_d  = AW'(cfg_prod - 1);
                        waddr_d  = '0;
                        o_d      = '0;
                        loaded_d = 1'b0;
                        state_d  = S_W;
                    end
                end
            end
            S_W: begin
                if (hs) begin
                    waddr_d = waddr_q + AW'(1);
                    if (waddr_q == wlast_q) begin
                        o_d     = '0;
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (asm_done) state_d = S_BIAS;
            end
            S_BIAS: begin
                if (asm_done) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (hs) begin
                    if (o_q == out_c_q - DIM_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        o_d     = o_q + DIM_W'(1);
                        state_d = S_MUL;
                    end
                end
            end
            S_DONE: begin
                load_done_d = 1'b1;
                loaded_d    = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Ready and busy are registered from the next state so they line up
        // with the state the following cycle operates in.
        s_ready_d   = (state_d == S_W) || (state_d == S_MUL) ||
                      (state_d == S_BIAS) || (state_d == S_SHIFT);
        load_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_c_q      <= '0;
            out_c_q     <= '0;
            o_q         <= '0;
            waddr_q     <= '0;
            wlast_q     <= '0;
            s_ready_q   <= 1'b0;
            load_busy_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_c_q      <= in_c_d;
            out_c_q     <= out_c_d;
            o_q         <= o_d;
            waddr_q     <= waddr_d;
            wlast_q     <= wlast_d;
            s_ready_q   <= s_ready_d;
            load_busy_q <= load_busy_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            loaded_q    <= loaded_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)     wmem[waddr_q]          <= s_if.s_data;
        if (mul_we)   mul_mem[OW'(o_q)]      <= asm_value[MUL_W-1:0];
        if (bias_we)  bias_mem[OW'(o_q)]     <= asm_value[BIAS_W-1:0];
        if (shift_we) shift_mem[OW'(o_q)]    <= s_if.s_data[SHIFT_W-1:0];
    end

    logic [AW-1:0] rd_addr;
    logic          in_ok, out_ok;

    always_comb begin
        rd_addr   = AW'(fc_out_idx) * AW'(in_c_q) + AW'(fc_in_idx);
        in_ok     = (fc_in_idx < in_c_q);
        out_ok    = (fc_out_idx < out_c_q);
        fc_weight = (in_ok && out_ok) ? $signed(wmem[rd_addr]) : '0;
        fc_mul    = out_ok ? $signed(mul_mem[OW'(fc_out_idx)])  : '0;
        fc_bias   = out_ok ? $signed(bias_mem[OW'(fc_out_idx)]) : '0;
        fc_shift  = out_ok ? shift_mem[OW'(fc_out_idx)]         : '0;
    end

endmodule : fc_param_store
`default_nettype wire

// File: tb/tb_fc_param_store.sv
`default_nettype none
// ============================================================================
// Module : tb_fc_param_store
// Brief  : Randomised load/readback bench for fc_param_store against an array model
// Rev    : 1.0
// ============================================================================
module tb_fc_param_store;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [15:0]       cfg_in_c, cfg_out_c;
    logic              load_busy, load_done, load_err, loaded;
    logic [15:0]       fc_in_idx, fc_out_idx;
    logic signed [7:0]  fc_weight;
    logic signed [15:0] fc_mul;
    logic signed [31:0] fc_bias;
    logic [5:0]         fc_shift;

    fc_param_store_if s_if ();

    fc_param_store dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .cfg_in_c   (cfg_in_c),
        .cfg_out_c  (cfg_out_c),
        .s_if       (s_if),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .loaded     (loaded),
        .fc_in_idx  (fc_in_idx),
        .fc_out_idx (fc_out_idx),
        .fc_weight  (fc_weight),
        .fc_mul     (fc_mul),
        .fc_bias    (fc_bias),
        .fc_shift   (fc_shift)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: what the stream said, as plain arrays.
    int          m_in_c, m_out_c;
    logic [7:0]  m_w[];
    logic [15:0] m_mul  [1024];
    logic [31:0] m_bias [1024];
    logic [5:0]  m_shift[1024];

    int done_cnt = 0, err_cnt = 0, hs_cnt = 0, done_hs = -1;
    bit stalled;

    always @(negedge clk) begin
        if (s_if.s_valid && s_if.s_ready) hs_cnt++;
        if (load_done) begin
            done_cnt++;
            done_hs = hs_cnt;
        end
        if (load_err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int ic, input int oc);
        cfg_in_c   = ic[15:0];
        cfg_out_c  = oc[15:0];
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit bubble);
        int t;
        if (bubble) begin
            s_if.s_valid = 1'b0;
            tick();
        end
        s_if.s_valid = 1'b1;
        s_if.s_data  = b;
        t = 0;
        while (s_if.s_ready !== 1'b1 && t < 20) begin
            stalled = 1'b1;
            tick();
            t++;
        end
        if (t == 20) check("ready_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic fill_random(input int ic, input int oc);
        m_in_c  = ic;
        m_out_c = oc;
        m_w     = new[ic * oc];
        foreach (m_w[a]) m_w[a] = 8'($urandom);
        for (int o = 0; o < oc; o++) begin
            m_mul[o]   = 16'($urandom);
            m_bias[o]  = $urandom;
            m_shift[o] = 6'($urandom);
        end
    endtask

    task automatic stream_load(input bit bubbles, input int ls_at);
        int base_done, t, total;
        logic [7:0] b;
        base_done = done_cnt;
        total     = m_in_c * m_out_c + m_out_c * 7;
        stalled   = 1'b0;
        start_load(m_in_c, m_out_c);
        hs_cnt = 0;
        check("busy_after_start", 64'(load_busy), 64'd1);
        check("loaded_cleared", 64'(loaded), 64'd0);
        for (int a = 0; a < m_in_c * m_out_c; a++) begin
            if (a == ls_at) begin
                load_start = 1'b1;
                cfg_in_c   = 16'd7;
                cfg_out_c  = 16'd7;
            end
            push_byte(m_w[a], bubbles);
            load_start = 1'b0;
        end
        for (int o = 0; o < m_out_c; o++) begin
            for (int j = 0; j < 2; j++) push_byte(m_mul[o][8*j +: 8], bubbles);
            for (int j = 0; j < 4; j++) push_byte(m_bias[o][8*j +: 8], bubbles);
            b = {2'($urandom), m_shift[o]};
            push_byte(b, bubbles);
        end
        s_if.s_valid = 1'b0;
        t = 0;
        while (loaded !== 1'b1 && t < 10) begin
            tick();
            t++;
        end
        tick();
        check("loaded_set", 64'(loaded), 64'd1);
        check("done_width", 64'(load_done), 64'd0);
        check("done_once", 64'(done_cnt - base_done), 64'd1);
        check("done_after_hs", 64'(done_hs), 64'(total));
        check("ready_held", 64'(stalled), 64'd0);
    endtask

    task automatic check_read(input int oi, input int ii);
        logic [7:0]  ew;
        logic [15:0] em;
        logic [31:0] eb;
        logic [5:0]  es;
        bit          o_in, i_in;
        fc_out_idx = oi[15:0];
        fc_in_idx  = ii[15:0];
        #1;
        o_in = (oi < m_out_c);
        i_in = (ii < m_in_c);
        ew = (o_in && i_in) ? m_w[oi * m_in_c + ii] : 8'd0;
        em = o_in ? m_mul[oi]   : 16'd0;
        eb = o_in ? m_bias[oi]  : 32'd0;
        es = o_in ? m_shift[oi] : 6'd0;
        check($sformatf("weight[%0d][%0d]", oi, ii), 64'($unsigned(fc_weight)), 64'(ew));
        check($sformatf("mul[%0d]", oi),   64'($unsigned(fc_mul)),  64'(em));
        check($sformatf("bias[%0d]", oi),  64'($unsigned(fc_bias)), 64'(eb));
        check($sformatf("shift[%0d]", oi), 64'(fc_shift), 64'(es));
    endtask

    task automatic random_reads(input int n);
        for (int k = 0; k < n; k++) begin
            check_read(int'($urandom_range(m_out_c, 0)), int'($urandom_range(m_in_c, 0)));
        end
    endtask

    task automatic expect_reject(input int ic, input int oc, input string tag);
        start_load(ic, oc);
        check({tag, "_err"}, 64'(load_err), 64'd1);
        check({tag, "_ready"}, 64'(s_if.s_ready), 64'd0);
        check({tag, "_busy"}, 64'(load_busy), 64'd0);
        tick();
        check({tag, "_err_width"}, 64'(load_err), 64'd0);
        check({tag, "_loaded"}, 64'(loaded), 64'd1);
    endtask

    initial begin
        int e0;
        rst_n        = 1'b0;
        load_start   = 1'b0;
        cfg_in_c     = '0;
        cfg_out_c    = '0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        fc_in_idx    = '0;
        fc_out_idx   = '0;
        m_in_c       = 0;
        m_out_c      = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(s_if.s_ready), 64'd0);
        check("rst_busy", 64'(load_busy), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(load_err), 64'd0);
        check("rst_loaded", 64'(loaded), 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed 3x2 load with known contents.
        m_in_c = 3;
        m_out_c = 2;
        m_w = new[6];
        foreach (m_w[a]) m_w[a] = 8'(a + 1);
        m_mul[0] = 16'h0102; m_bias[0] = 32'hFFFF_FFFB; m_shift[0] = 6'd7;
        m_mul[1] = 16'h0304; m_bias[1] = 32'd100;       m_shift[1] = 6'd63;
        stream_load(1'b0, -1);
        fc_out_idx = 16'd1;
        fc_in_idx  = 16'd2;
        #1;
        check("p1_weight", 64'($unsigned(fc_weight)), 64'd6);
        check("p1_mul", 64'($unsigned(fc_mul)), 64'h0304);
        check("p1_bias", 64'($unsigned(fc_bias)), 64'd100);
        check("p1_shift", 64'(fc_shift), 64'd63);
        for (int o = 0; o <= 2; o++)
            for (int i = 0; i <= 3; i++) check_read(o, i);

        // Stray load_start mid-weights, then the bubbled variant.
        stream_load(1'b0, 2);
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 3; i++) check_read(o, i);
        stream_load(1'b1, -1);
        for (int o = 0; o <= 2; o++)
            for (int i = 0; i <= 3; i++) check_read(o, i);

        // Rejected configurations leave everything as it was.
        e0 = err_cnt;
        expect_reject(0, 2, "in_zero");
        expect_reject(3, 1025, "out_big");
        check("err_count", 64'(err_cnt - e0), 64'd2);
        check_read(1, 2);

        // Randomised loads.
        for (int r = 0; r < 4; r++) begin
            fill_random(int'($urandom_range(8, 1)), int'($urandom_range(6, 1)));
            stream_load(1'($urandom), -1);
            random_reads(10);
        end

        // Reset in the middle of the weight phase.
        fill_random(4, 2);
        start_load(4, 2);
        for (int a = 0; a < 4; a++) push_byte(m_w[a], 1'b0);
        s_if.s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(s_if.s_ready), 64'd0);
        check("abort_busy", 64'(load_busy), 64'd0);
        check("abort_done", 64'(load_done), 64'd0);
        check("abort_err", 64'(load_err), 64'd0);
        check("abort_loaded", 64'(loaded), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        fill_random(2, 3);
        stream_load(1'b0, -1);
        random_reads(10);

        // Widest input dimension: the last weight address must not wrap.
        m_in_c = 1024;
        m_out_c = 1;
        m_w = new[1024];
        foreach (m_w[a]) m_w[a] = 8'(a & 8'hFF);
        m_mul[0] = 16'($urandom); m_bias[0] = $urandom; m_shift[0] = 6'($urandom);
        stream_load(1'b0, -1);
        fc_out_idx = 16'd0;
        fc_in_idx  = 16'd1023;
        #1;
        check("wide_last", 64'($unsigned(fc_weight)), 64'hFF);
        check_read(0, 1023);
        check_read(0, 1024);
        check_read(0, 0);
        check_read(0, 256);
        check_read(1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fc_param_store
`default_nettype wire
